// File: rtl/ip_packet_tx.sv
// rtl/ip_packet_tx.sv - Ethernet/IPv4 framer streaming header plus payload bytes; optional IP_TX_CHECKSUM_EN.
module ip_packet_tx #(
    parameter int          USER_DATA_BYTES = 10,
    parameter logic [15:0] ETHERTYPE       = 16'h0008,
    parameter logic [95:0] IP_HDR_MISC     = 96'h0
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [31:0]                  ACCELERATOR_IP_ADDRESS,
    input  logic [47:0]                  ACCELERATOR_MAC_ADDRESS,
    input  logic [31:0]                  DST_IP_ADDRESS,
    input  logic [47:0]                  DST_MAC_ADDRESS,
    input  logic [USER_DATA_BYTES*8-1:0] DATA_FRAME,
    input  logic                         FRAME_VALID,
    output logic                         FRAME_READY,
    output logic [7:0]                   MAC_DATA_IN,
    output logic                         MAC_DATA_VALID,
    input  logic                         MAC_DATA_READY,
    output logic                         MAC_DATA_LAST,
    output logic                         MAC_DATA_TUSER
);

    typedef enum logic [1:0] {IDLE, ETH_HDR, IP_HDR, PAYLOAD} state_t;

    localparam logic [15:0] LAST_IDX = 16'(USER_DATA_BYTES - 1);

    state_t                       state;
    logic [15:0]                  cnt;
    logic [USER_DATA_BYTES*8-1:0] frame_r;
    logic [47:0]                  dst_mac_r;
    logic [31:0]                  dst_ip_r;
    logic [47:0]                  acc_mac_r;
    logic [31:0]                  acc_ip_r;

    logic         beat;
    logic [15:0]  cnt_n;
    logic [111:0] eth_hdr;
    logic [95:0]  misc_eff;
    logic [159:0] ip_hdr;
    logic [7:0]   eth_next;
    logic [7:0]   ip_next;
    logic [7:0]   pay_next;

    assign MAC_DATA_TUSER = 1'b0;

    assign beat     = MAC_DATA_VALID && MAC_DATA_READY;
    assign cnt_n    = cnt + 16'd1;
    assign eth_hdr  = {ETHERTYPE, acc_mac_r, dst_mac_r};
    assign ip_hdr   = {dst_ip_r, acc_ip_r, misc_eff};
    // The byte for the next beat is selected by shifting the flat header vectors.
    assign eth_next = 8'(eth_hdr >> {cnt_n, 3'b000});
    assign ip_next  = 8'(ip_hdr >> {cnt_n, 3'b000});
    assign pay_next = 8'(frame_r >> {cnt_n, 3'b000});

`ifdef IP_TX_CHECKSUM_EN
    logic [159:0] csum_hdr;
    logic [19:0]  csum_sum;
    logic [16:0]  csum_fold;
    logic [15:0]  csum;

    always_comb begin
        csum_hdr = {dst_ip_r, acc_ip_r, 16'h0000, IP_HDR_MISC[79:0]};
        csum_sum = '0;
        for (int i = 0; i < 10; i++) begin
            csum_sum = csum_sum + 20'({csum_hdr[16*i +: 8], csum_hdr[16*i+8 +: 8]});
        end
        // Two folds suffice: ten words never carry more than 4 bits past 16.
        csum_fold = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
        csum      = ~(csum_fold[15:0] + 16'(csum_fold[16]));
    end

    assign misc_eff = {csum[7:0], csum[15:8], IP_HDR_MISC[79:0]};
`else
    assign misc_eff = IP_HDR_MISC;
`endif

    always_ff @(posedge ACLK or negedge ARESET) begin
        if (!ARESET) begin
            state          <= IDLE;
            cnt            <= '0;
            frame_r        <= '0;
            dst_mac_r      <= '0;
            dst_ip_r       <= '0;
            acc_mac_r      <= '0;
            acc_ip_r       <= '0;
            FRAME_READY    <= 1'b1;
            MAC_DATA_IN    <= 8'h00;
            MAC_DATA_VALID <= 1'b0;
            MAC_DATA_LAST  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (FRAME_VALID) begin
                        frame_r        <= DATA_FRAME;
                        dst_mac_r      <= DST_MAC_ADDRESS;
                        dst_ip_r       <= DST_IP_ADDRESS;
                        acc_mac_r      <= ACCELERATOR_MAC_ADDRESS;
                        acc_ip_r       <= ACCELERATOR_IP_ADDRESS;
                        state          <= ETH_HDR;
                        cnt            <= '0;
                        FRAME_READY    <= 1'b0;
                        MAC_DATA_VALID <= 1'b1;
                        MAC_DATA_LAST  <= 1'b0;
                        // Registers are loading this edge, so byte 0 comes straight from the port.
                        MAC_DATA_IN    <= DST_MAC_ADDRESS[7:0];
                    end
                end
                ETH_HDR: begin
                    if (beat) begin
                        if (cnt == 16'd13) begin
                            state       <= IP_HDR;
                            cnt         <= '0;
                            MAC_DATA_IN <= ip_hdr[7:0];
                        end else begin
                            cnt         <= cnt_n;
                            MAC_DATA_IN <= eth_next;
                        end
                    end
                end
                IP_HDR: begin
                    if (beat) begin
                        if (cnt == 16'd19) begin
                            state         <= PAYLOAD;
                            cnt           <= '0;
                            MAC_DATA_IN   <= frame_r[7:0];
                            MAC_DATA_LAST <= (USER_DATA_BYTES == 1);
                        end else begin
                            cnt         <= cnt_n;
                            MAC_DATA_IN <= ip_next;
                        end
                    end
                end
                PAYLOAD: begin
                    if (beat) begin
                        if (cnt == LAST_IDX) begin
                            state          <= IDLE;
                            cnt            <= '0;
                            FRAME_READY    <= 1'b1;
                            MAC_DATA_VALID <= 1'b0;
                            MAC_DATA_LAST  <= 1'b0;
                            MAC_DATA_IN    <= 8'h00;
                        end else begin
                            cnt           <= cnt_n;
                            MAC_DATA_IN   <= pay_next;
                            MAC_DATA_LAST <= (cnt_n == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ip_packet_tx.sv
// tb/tb_ip_packet_tx.sv - self-checking bench for ip_packet_tx against a byte-list reference model.
module tb_ip_packet_tx;

    localparam int          N       = 10;
    localparam int          EXP_LEN = 34 + N;
    localparam logic [15:0] ETYPE   = 16'h0008;
    localparam logic [95:0] MISC    = 96'h0;

    logic         ACLK = 1'b0;
    logic         ARESET = 1'b0;
    logic [31:0]  ACCELERATOR_IP_ADDRESS = '0;
    logic [47:0]  ACCELERATOR_MAC_ADDRESS = '0;
    logic [31:0]  DST_IP_ADDRESS = '0;
    logic [47:0]  DST_MAC_ADDRESS = '0;
    logic [N*8-1:0] DATA_FRAME = '0;
    logic         FRAME_VALID = 1'b0;
    logic         FRAME_READY;
    logic [7:0]   MAC_DATA_IN;
    logic         MAC_DATA_VALID;
    logic         MAC_DATA_READY = 1'b0;
    logic         MAC_DATA_LAST;
    logic         MAC_DATA_TUSER;

    ip_packet_tx dut (
        .ACLK                    (ACLK),
        .ARESET                  (ARESET),
        .ACCELERATOR_IP_ADDRESS  (ACCELERATOR_IP_ADDRESS),
        .ACCELERATOR_MAC_ADDRESS (ACCELERATOR_MAC_ADDRESS),
        .DST_IP_ADDRESS          (DST_IP_ADDRESS),
        .DST_MAC_ADDRESS         (DST_MAC_ADDRESS),
        .DATA_FRAME              (DATA_FRAME),
        .FRAME_VALID             (FRAME_VALID),
        .FRAME_READY             (FRAME_READY),
        .MAC_DATA_IN             (MAC_DATA_IN),
        .MAC_DATA_VALID          (MAC_DATA_VALID),
        .MAC_DATA_READY          (MAC_DATA_READY),
        .MAC_DATA_LAST           (MAC_DATA_LAST),
        .MAC_DATA_TUSER          (MAC_DATA_TUSER)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] got[$];
    bit         got_last[$];
    int         vcycles;
    int         drops;
    int         stalls_bad;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] gb(input int i);
        return (i < got.size()) ? got[i] : 8'hxx;
    endfunction

    function automatic logic gl(input int i);
        return (i < got_last.size()) ? got_last[i] : 1'bx;
    endfunction

    // Expected wire bytes built directly from the frame layout rules.
    function automatic void build_exp();
        logic [7:0] ip [20];
        int unsigned sum;
        logic [15:0] cs;
        exp_q.delete();
        for (int k = 0; k < 6; k++) exp_q.push_back(8'(DST_MAC_ADDRESS >> (8 * k)));
        for (int k = 0; k < 6; k++) exp_q.push_back(8'(ACCELERATOR_MAC_ADDRESS >> (8 * k)));
        exp_q.push_back(8'(ETYPE));
        exp_q.push_back(8'(ETYPE >> 8));
        for (int k = 0; k < 12; k++) ip[k] = 8'(MISC >> (8 * k));
        for (int k = 0; k < 4; k++) ip[12 + k] = 8'(ACCELERATOR_IP_ADDRESS >> (8 * k));
        for (int k = 0; k < 4; k++) ip[16 + k] = 8'(DST_IP_ADDRESS >> (8 * k));
`ifdef IP_TX_CHECKSUM_EN
        ip[10] = 8'h00;
        ip[11] = 8'h00;
        sum = 0;
        for (int i = 0; i < 10; i++) sum += (int'(ip[2 * i]) << 8) + int'(ip[2 * i + 1]);
        while ((sum >> 16) != 0) sum = (sum & 32'hffff) + (sum >> 16);
        cs = ~16'(sum);
        ip[10] = cs[15:8];
        ip[11] = cs[7:0];
`else
        sum = 0;
        cs = 16'h0;
`endif
        for (int k = 0; k < 20; k++) exp_q.push_back(ip[k]);
        for (int k = 0; k < N; k++) exp_q.push_back(8'(DATA_FRAME >> (8 * k)));
    endfunction

    // mode 0: ready held 1; 1: ready 0,1,0,1...; 2: random ready.
    task automatic run_frame(input int mode, input int busy_at, input int reset_at);
        int beats;
        bit first;
        bit busy_done;
        logic pv, pr, pl, r;
        logic [7:0] pd;
        got.delete();
        got_last.delete();
        vcycles = 0;
        drops = 0;
        stalls_bad = 0;
        beats = 0;
        first = 1;
        busy_done = 0;
        pv = 0; pr = 0; pl = 0; pd = 0;
        @(negedge ACLK);
        chk("ready_before_accept", FRAME_READY, 1);
        FRAME_VALID = 1'b1;
        @(negedge ACLK);
        FRAME_VALID = 1'b0;
        for (int c = 0; c < 400 && beats < EXP_LEN; c++) begin
            if (reset_at >= 0 && beats == reset_at) begin
                ARESET = 1'b0;
                #1;
                chk("midreset_valid", MAC_DATA_VALID, 0);
                chk("midreset_last", MAC_DATA_LAST, 0);
                chk("midreset_data", MAC_DATA_IN, 0);
                return;
            end
            if (!MAC_DATA_VALID) drops++;
            if (!first && pv && !pr &&
                (MAC_DATA_IN !== pd || MAC_DATA_VALID !== 1'b1 || MAC_DATA_LAST !== pl))
                stalls_bad++;
            case (mode)
                0: r = 1'b1;
                1: r = (c % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            MAC_DATA_READY = r;
            if (MAC_DATA_VALID) vcycles++;
            if (MAC_DATA_VALID && r) begin
                got.push_back(MAC_DATA_IN);
                got_last.push_back(MAC_DATA_LAST);
                beats++;
            end
            if (busy_at >= 0 && beats == busy_at && !busy_done) begin
                FRAME_VALID     = 1'b1;
                DATA_FRAME      = ~DATA_FRAME;
                DST_MAC_ADDRESS = ~DST_MAC_ADDRESS;
                DST_IP_ADDRESS  = ~DST_IP_ADDRESS;
                busy_done = 1;
            end else begin
                FRAME_VALID = 1'b0;
            end
            pv = MAC_DATA_VALID;
            pd = MAC_DATA_IN;
            pl = MAC_DATA_LAST;
            pr = r;
            first = 0;
            @(negedge ACLK);
        end
        FRAME_VALID = 1'b0;
        chk("beat_count", beats, EXP_LEN);
        if (mode != 2) chk("valid_cycles", vcycles, (mode == 0) ? EXP_LEN : 2 * EXP_LEN);
        chk("valid_drops", drops, 0);
        chk("stall_stable", stalls_bad, 0);
        chk("valid_after_frame", MAC_DATA_VALID, 0);
        chk("ready_after_frame", FRAME_READY, 1);
    endtask

    task automatic compare_frame(input string tag);
        int lastbad;
        lastbad = 0;
        for (int i = 0; i < EXP_LEN; i++) chk($sformatf("%s_byte%0d", tag, i), gb(i), exp_q[i]);
        for (int i = 0; i < got_last.size(); i++) if (got_last[i] != (i == EXP_LEN - 1)) lastbad++;
        chk({tag, "_last_misplaced"}, lastbad, 0);
        chk({tag, "_last_final"}, gl(EXP_LEN - 1), 1);
    endtask

    task automatic set_happy();
        DST_MAC_ADDRESS         = 48'h112233445566;
        DST_IP_ADDRESS          = 32'h0200000a;
        ACCELERATOR_MAC_ADDRESS = 48'hccffffffffff;
        ACCELERATOR_IP_ADDRESS  = 32'hbbaaaaaa;
        for (int k = 0; k < N; k++) DATA_FRAME[8 * k +: 8] = 8'(k);
    endtask

    task automatic set_random();
        DST_MAC_ADDRESS         = {16'($urandom), $urandom};
        DST_IP_ADDRESS          = $urandom;
        ACCELERATOR_MAC_ADDRESS = {16'($urandom), $urandom};
        ACCELERATOR_IP_ADDRESS  = $urandom;
        DATA_FRAME              = {16'($urandom), $urandom, $urandom};
    endtask

    initial begin
        int idle_valid;
        repeat (3) @(negedge ACLK);
        chk("reset_valid", MAC_DATA_VALID, 0);
        chk("reset_last", MAC_DATA_LAST, 0);
        chk("reset_tuser", MAC_DATA_TUSER, 0);
        chk("reset_data", MAC_DATA_IN, 0);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("reset_frame_ready", FRAME_READY, 1);

        set_happy();
        build_exp();
        run_frame(0, -1, -1);
        compare_frame("happy");
        chk("happy_b0", gb(0), 8'h66);
        chk("happy_b6", gb(6), 8'hff);
        chk("happy_b26_29", {gb(26), gb(27), gb(28), gb(29)}, 32'haaaaaabb);
        chk("happy_b43", gb(43), 8'h09);
        chk("happy_tuser", MAC_DATA_TUSER, 0);

        set_happy();
        build_exp();
        run_frame(1, -1, -1);
        compare_frame("backpressure");

        set_happy();
        build_exp();
        run_frame(0, 5, -1);
        compare_frame("busy");
        idle_valid = 0;
        repeat (6) begin
            @(negedge ACLK);
            if (MAC_DATA_VALID) idle_valid++;
        end
        chk("busy_no_second_frame", idle_valid, 0);

        for (int f = 0; f < 3; f++) begin
            set_random();
            build_exp();
            run_frame(2, -1, -1);
            compare_frame($sformatf("rand%0d", f));
        end

        set_random();
        run_frame(0, -1, 20);
        repeat (2) @(negedge ACLK);
        chk("inreset_valid", MAC_DATA_VALID, 0);
        ARESET = 1'b1;
        @(negedge ACLK);
        chk("postreset_ready", FRAME_READY, 1);
        chk("postreset_valid", MAC_DATA_VALID, 0);
        set_random();
        build_exp();
        run_frame(0, -1, -1);
        compare_frame("postreset");

        set_happy();
        ACCELERATOR_IP_ADDRESS = 32'h0100000a;
        DST_IP_ADDRESS         = 32'h0200000a;
        build_exp();
        run_frame(0, -1, -1);
        compare_frame("csum");
`ifdef IP_TX_CHECKSUM_EN
        chk("csum_b10", gb(24), 8'heb);
        chk("csum_b11", gb(25), 8'hfc);
`else
        chk("csum_b10", gb(24), 8'h00);
        chk("csum_b11", gb(25), 8'h00);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
